// File: rtl/fifo_pair.sv
// fifo_pair: host-to-machine TX FIFO and machine-to-host RX FIFO sharing one
// 2*DEPTH-word store. The join inputs lend one FIFO's half to the other.
// Ports:
//   clk, reset (async, active-low)
//   sm_en, tx_pull, tx_dout, tx_empty        machine side of TX (fall-through head)
//   rx_push, rx_din, rx_full                 machine side of RX
//   host_wr, host_wdata, tx_full             host side of TX
//   host_rd, host_rdata, rx_empty            host side of RX (fall-through head)
//   tx_level, rx_level                       occupancy
//   join_tx, join_rx, clear                  configuration / flush
//   dbg_flags, dbg_clr                       sticky {tx_over, rx_under, tx_stall, rx_stall}, W1C
module fifo_pair #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sm_en,
   input  logic                     tx_pull,
   output logic [31:0]              tx_dout,
   output logic                     tx_empty,
   input  logic                     rx_push,
   input  logic [31:0]              rx_din,
   output logic                     rx_full,
   input  logic                     host_wr,
   input  logic [31:0]              host_wdata,
   input  logic                     host_rd,
   output logic [31:0]              host_rdata,
   output logic                     tx_full,
   output logic                     rx_empty,
   output logic [$clog2(2*DEPTH):0] tx_level,
   output logic [$clog2(2*DEPTH):0] rx_level,
   input  logic                     join_tx,
   input  logic                     join_rx,
   input  logic                     clear,
   output logic [3:0]               dbg_flags,
   input  logic [3:0]               dbg_clr
);
   localparam int unsigned NW = 2 * DEPTH;
   localparam int unsigned PW = $clog2(NW);
   localparam int unsigned LW = PW + 1;

   logic [31:0]   mem [NW];

   logic [1:0]    cfg_q;
   logic          cfg_vld_q;
   logic [PW-1:0] tx_rptr_q, tx_wptr_q, rx_rptr_q, rx_wptr_q;
   logic [LW-1:0] tx_lvl_q, rx_lvl_q;

   logic [1:0]    cfg_cur, cfg_eff;
   logic [LW-1:0] tx_cap, rx_cap, tx_cap_n, rx_cap_n;
   logic [PW-1:0] rx_base;
   logic          flush;
   logic          tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
   logic          tx_wr_acc, tx_rd_acc, rx_wr_acc, rx_rd_acc;
   logic [PW-1:0] tx_rptr_n, tx_wptr_n, rx_rptr_n, rx_wptr_n;
   logic [LW-1:0] tx_lvl_n, rx_lvl_n;
   logic [31:0]   tx_head_n, rx_head_n;
   logic          tx_full_n, rx_full_n;
   logic [3:0]    flag_set, flags_n;

   // Capacity of one FIFO given its own join bit and the other FIFO's.
   function automatic logic [LW-1:0] cap_of(input logic own, input logic other);
      logic [LW-1:0] c;
      c = LW'(DEPTH);
      if (own && !other)
         c = LW'(NW);
      else if (!own && other)
         c = '0;
      return c;
   endfunction

   // Pointer advance modulo the current capacity.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p, input logic [LW-1:0] cap);
      return ((LW'(p) + LW'(1)) == cap) ? '0 : p + PW'(1);
   endfunction

   // Access arbitration, pointer/level update and next head word.
   always_comb begin
      cfg_cur  = {join_tx, join_rx};
      // Before the first post-reset edge the live configuration is adopted without a flush.
      cfg_eff  = cfg_vld_q ? cfg_q : cfg_cur;
      tx_cap   = cap_of(cfg_eff[1], cfg_eff[0]);
      rx_cap   = cap_of(cfg_eff[0], cfg_eff[1]);
      tx_cap_n = cap_of(join_tx, join_rx);
      rx_cap_n = cap_of(join_rx, join_tx);
      // RX borrows the low half only when it owns the whole store.
      rx_base  = (cfg_eff == 2'b01) ? '0 : PW'(DEPTH);
      flush    = clear | (cfg_vld_q & (cfg_cur != cfg_q));

      tx_full_c  = (tx_cap == '0) || (tx_lvl_q == tx_cap);
      tx_empty_c = (tx_lvl_q == '0);
      rx_full_c  = (rx_cap == '0) || (rx_lvl_q == rx_cap);
      rx_empty_c = (rx_lvl_q == '0);

      // A full FIFO still takes a write when its head is popped in the same cycle.
      tx_rd_acc = sm_en & tx_pull & ~tx_empty_c & ~flush;
      tx_wr_acc = host_wr & (~tx_full_c | tx_rd_acc) & ~flush;
      rx_rd_acc = host_rd & ~rx_empty_c & ~flush;
      rx_wr_acc = sm_en & rx_push & (~rx_full_c | rx_rd_acc) & ~flush;

      flag_set[3] = host_wr & ~tx_wr_acc & ~flush;
      flag_set[2] = host_rd & ~rx_rd_acc & ~flush;
      flag_set[1] = sm_en & tx_pull & ~tx_rd_acc & ~flush;
      flag_set[0] = sm_en & rx_push & ~rx_wr_acc & ~flush;
      flags_n     = (dbg_flags & ~dbg_clr) | flag_set;

      tx_rptr_n = tx_rd_acc ? ptr_inc(tx_rptr_q, tx_cap) : tx_rptr_q;
      tx_wptr_n = tx_wr_acc ? ptr_inc(tx_wptr_q, tx_cap) : tx_wptr_q;
      tx_lvl_n  = tx_lvl_q + LW'(tx_wr_acc) - LW'(tx_rd_acc);
      rx_rptr_n = rx_rd_acc ? ptr_inc(rx_rptr_q, rx_cap) : rx_rptr_q;
      rx_wptr_n = rx_wr_acc ? ptr_inc(rx_wptr_q, rx_cap) : rx_wptr_q;
      rx_lvl_n  = rx_lvl_q + LW'(rx_wr_acc) - LW'(rx_rd_acc);
      if (flush) begin
         tx_rptr_n = '0;
         tx_wptr_n = '0;
         tx_lvl_n  = '0;
         rx_rptr_n = '0;
         rx_wptr_n = '0;
         rx_lvl_n  = '0;
      end

      // Next head bypasses the store when this cycle's write lands at the new head.
      tx_head_n = '0;
      if (tx_lvl_n != '0)
         tx_head_n = (tx_wr_acc && (tx_wptr_q == tx_rptr_n)) ? host_wdata : mem[tx_rptr_n];
      rx_head_n = '0;
      if (rx_lvl_n != '0)
         rx_head_n = (rx_wr_acc && (rx_wptr_q == rx_rptr_n)) ? rx_din : mem[rx_base + rx_rptr_n];

      tx_full_n = (tx_cap_n == '0) || (tx_lvl_n == tx_cap_n);
      rx_full_n = (rx_cap_n == '0) || (rx_lvl_n == rx_cap_n);
   end

   // Control state and registered status/head outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_q      <= '0;
         cfg_vld_q  <= 1'b0;
         tx_rptr_q  <= '0;
         tx_wptr_q  <= '0;
         tx_lvl_q   <= '0;
         rx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_lvl_q   <= '0;
         tx_dout    <= '0;
         host_rdata <= '0;
         tx_full    <= 1'b0;
         tx_empty   <= 1'b1;
         rx_full    <= 1'b0;
         rx_empty   <= 1'b1;
         dbg_flags  <= '0;
      end else begin
         cfg_q      <= cfg_cur;
         cfg_vld_q  <= 1'b1;
         tx_rptr_q  <= tx_rptr_n;
         tx_wptr_q  <= tx_wptr_n;
         tx_lvl_q   <= tx_lvl_n;
         rx_rptr_q  <= rx_rptr_n;
         rx_wptr_q  <= rx_wptr_n;
         rx_lvl_q   <= rx_lvl_n;
         tx_dout    <= tx_head_n;
         host_rdata <= rx_head_n;
         tx_full    <= tx_full_n;
         tx_empty   <= (tx_lvl_n == '0);
         rx_full    <= rx_full_n;
         rx_empty   <= (rx_lvl_n == '0);
         dbg_flags  <= flags_n;
      end
   end

   // Shared word store; TX and RX regions never overlap for a given configuration.
   always_ff @(posedge clk) begin
      if (tx_wr_acc)
         mem[tx_wptr_q] <= host_wdata;
      if (rx_wr_acc)
         mem[rx_base + rx_wptr_q] <= rx_din;
   end

   assign tx_level = tx_lvl_q;
   assign rx_level = rx_lvl_q;

endmodule

// File: tb/tb_fifo_pair.sv
// Bench for fifo_pair: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_fifo_pair;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(2*DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          sm_en, tx_pull, rx_push, host_wr, host_rd;
   logic          join_tx, join_rx, clear;
   logic [31:0]   rx_din, host_wdata;
   logic [3:0]    dbg_clr;
   logic [31:0]   tx_dout, host_rdata;
   logic          tx_empty, tx_full, rx_empty, rx_full;
   logic [LW-1:0] tx_level, rx_level;
   logic [3:0]    dbg_flags;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fifo_pair #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .sm_en(sm_en), .tx_pull(tx_pull), .tx_dout(tx_dout),
      .tx_empty(tx_empty), .rx_push(rx_push), .rx_din(rx_din), .rx_full(rx_full),
      .host_wr(host_wr), .host_wdata(host_wdata), .host_rd(host_rd),
      .host_rdata(host_rdata), .tx_full(tx_full), .rx_empty(rx_empty),
      .tx_level(tx_level), .rx_level(rx_level), .join_tx(join_tx), .join_rx(join_rx),
      .clear(clear), .dbg_flags(dbg_flags), .dbg_clr(dbg_clr)
   );

   typedef struct {
      logic        wr;
      logic [31:0] wd;
      logic        en;
      logic        pull;
      logic [3:0]  clr;
      logic [3:0]  e_lvl;
      logic        e_full;
      logic        e_empty;
      logic [31:0] e_dout;
      logic [3:0]  e_flags;
   } vec_t;

   vec_t tbl [13];

   // reference model state
   logic [31:0] mq_tx [$];
   logic [31:0] mq_rx [$];
   logic [3:0]  m_flags;
   logic [1:0]  m_cfg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      sm_en = 0; tx_pull = 0; rx_push = 0; host_wr = 0; host_rd = 0;
      clear = 0; dbg_clr = 4'h0; rx_din = '0; host_wdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_all();
      idle();
      clear = 1; dbg_clr = 4'hF;
      step();
      idle();
   endtask

   function automatic int mcap(input logic own, input logic other);
      if (own == other) return DEPTH;
      return own ? 2*DEPTH : 0;
   endfunction

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      int tcap, rcap;
      bit t_full, t_empty, r_full, r_empty, pull_ok, wr_ok, push_ok, rd_ok;
      logic [3:0] set;
      logic [31:0] junk;
      tcap = mcap(m_cfg[1], m_cfg[0]);
      rcap = mcap(m_cfg[0], m_cfg[1]);
      set = 4'h0;
      if (clear || ({join_tx, join_rx} != m_cfg)) begin
         mq_tx.delete();
         mq_rx.delete();
      end else begin
         t_full  = (mq_tx.size() == tcap);
         t_empty = (mq_tx.size() == 0);
         r_full  = (mq_rx.size() == rcap);
         r_empty = (mq_rx.size() == 0);
         pull_ok = sm_en && tx_pull && !t_empty;
         wr_ok   = host_wr && (!t_full || pull_ok);
         rd_ok   = host_rd && !r_empty;
         push_ok = sm_en && rx_push && (!r_full || rd_ok);
         if (host_wr && !wr_ok) set[3] = 1'b1;
         if (host_rd && !rd_ok) set[2] = 1'b1;
         if (sm_en && tx_pull && !pull_ok) set[1] = 1'b1;
         if (sm_en && rx_push && !push_ok) set[0] = 1'b1;
         if (pull_ok) junk = mq_tx.pop_front();
         if (wr_ok) mq_tx.push_back(host_wdata);
         if (rd_ok) junk = mq_rx.pop_front();
         if (push_ok) mq_rx.push_back(rx_din);
      end
      m_flags = (m_flags & ~dbg_clr) | set;
      m_cfg = {join_tx, join_rx};
   endtask

   task automatic model_check();
      int tcap, rcap;
      tcap = mcap(m_cfg[1], m_cfg[0]);
      rcap = mcap(m_cfg[0], m_cfg[1]);
      chk("rnd_tx_level", 32'(tx_level), 32'(mq_tx.size()));
      chk("rnd_rx_level", 32'(rx_level), 32'(mq_rx.size()));
      chk("rnd_tx_full", 32'(tx_full), 32'(mq_tx.size() == tcap));
      chk("rnd_rx_full", 32'(rx_full), 32'(mq_rx.size() == rcap));
      chk("rnd_tx_empty", 32'(tx_empty), 32'(mq_tx.size() == 0));
      chk("rnd_rx_empty", 32'(rx_empty), 32'(mq_rx.size() == 0));
      chk("rnd_tx_dout", tx_dout, (mq_tx.size() != 0) ? mq_tx[0] : 32'h0);
      chk("rnd_host_rdata", host_rdata, (mq_rx.size() != 0) ? mq_rx[0] : 32'h0);
      chk("rnd_flags", 32'(dbg_flags), 32'(m_flags));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // wr wd en pull clr | lvl full empty dout flags
      tbl[0]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 4'h0, 4'd1, 1'b0, 1'b0, 32'hA1, 4'h0};
      tbl[1]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 4'h0, 4'd2, 1'b0, 1'b0, 32'hA1, 4'h0};
      tbl[2]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 4'h0, 4'd3, 1'b0, 1'b0, 32'hA1, 4'h0};
      tbl[3]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 4'h0, 4'd4, 1'b1, 1'b0, 32'hA1, 4'h0};
      tbl[4]  = '{1'b1, 32'hA5, 1'b0, 1'b0, 4'h0, 4'd4, 1'b1, 1'b0, 32'hA1, 4'h8};
      tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 4'h0, 4'd3, 1'b0, 1'b0, 32'hA2, 4'h8};
      tbl[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 4'h0, 4'd2, 1'b0, 1'b0, 32'hA3, 4'h8};
      tbl[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 4'h0, 4'd1, 1'b0, 1'b0, 32'hA4, 4'h8};
      tbl[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 4'h0, 4'd0, 1'b0, 1'b1, 32'h00, 4'h8};
      tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 4'h0, 4'd0, 1'b0, 1'b1, 32'h00, 4'hA};
      tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b1, 32'h00, 4'h0};
      tbl[11] = '{1'b1, 32'hB0, 1'b1, 1'b1, 4'h0, 4'd1, 1'b0, 1'b0, 32'hB0, 4'h2};
      tbl[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 4'h2, 4'd1, 1'b0, 1'b0, 32'hB0, 4'h0};

      reset = 0; join_tx = 0; join_rx = 0;
      idle();
      #12;
      chk("rst_tx_empty", 32'(tx_empty), 32'd1);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);
      chk("rst_tx_full", 32'(tx_full), 32'd0);
      chk("rst_rx_full", 32'(rx_full), 32'd0);
      chk("rst_tx_level", 32'(tx_level), 32'd0);
      chk("rst_rx_level", 32'(rx_level), 32'd0);
      chk("rst_flags", 32'(dbg_flags), 32'd0);
      chk("rst_tx_dout", tx_dout, 32'd0);
      chk("rst_host_rdata", host_rdata, 32'd0);
      reset = 1;

      // table: fill to full, overflow, drain in order, pull on empty, W1C
      for (int i = 0; i < 13; i++) begin
         idle();
         host_wr = tbl[i].wr; host_wdata = tbl[i].wd;
         sm_en = tbl[i].en; tx_pull = tbl[i].pull; dbg_clr = tbl[i].clr;
         step();
         chk($sformatf("row%0d_lvl", i), 32'(tx_level), 32'(tbl[i].e_lvl));
         chk($sformatf("row%0d_full", i), 32'(tx_full), 32'(tbl[i].e_full));
         chk($sformatf("row%0d_empty", i), 32'(tx_empty), 32'(tbl[i].e_empty));
         chk($sformatf("row%0d_dout", i), tx_dout, tbl[i].e_dout);
         chk($sformatf("row%0d_flags", i), 32'(dbg_flags), 32'(tbl[i].e_flags));
      end

      // pull held without sm_en is ignored; one sm_en pulse pops once
      flush_all();
      chk("clr_tx_level", 32'(tx_level), 32'd0);
      for (int i = 0; i < 3; i++) begin
         host_wr = 1; host_wdata = 32'hD0 + 32'(i);
         step();
      end
      idle();
      tx_pull = 1;
      for (int i = 0; i < 10; i++) step();
      chk("noen_tx_level", 32'(tx_level), 32'd3);
      chk("noen_flags", 32'(dbg_flags), 32'd0);
      sm_en = 1;
      step();
      sm_en = 0;
      chk("pulse_tx_level", 32'(tx_level), 32'd2);
      chk("pulse_tx_dout", tx_dout, 32'hD1);
      step();
      chk("after_pulse_level", 32'(tx_level), 32'd2);

      // RX full with simultaneous push and host read
      flush_all();
      for (int i = 0; i < 4; i++) begin
         sm_en = 1; rx_push = 1; rx_din = 32'hC0 + 32'(i);
         step();
      end
      idle();
      chk("rxfull_level", 32'(rx_level), 32'd4);
      chk("rxfull_full", 32'(rx_full), 32'd1);
      chk("rxfull_head", host_rdata, 32'hC0);
      sm_en = 1; rx_push = 1; rx_din = 32'hC4; host_rd = 1;
      step();
      idle();
      chk("rxboth_level", 32'(rx_level), 32'd4);
      chk("rxboth_full", 32'(rx_full), 32'd1);
      chk("rxboth_flags", 32'(dbg_flags), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("rxdrain%0d", i), host_rdata, 32'hC0 + 32'(i));
         host_rd = 1;
         step();
         idle();
      end
      chk("rxdrain_empty", 32'(rx_empty), 32'd1);
      chk("rxdrain_rdata", host_rdata, 32'd0);

      // join_tx: TX takes the whole store, RX becomes capacity 0
      flush_all();
      join_tx = 1;
      step();
      chk("join_tx_level0", 32'(tx_level), 32'd0);
      for (int i = 0; i < 8; i++) begin
         host_wr = 1; host_wdata = 32'hE0 + 32'(i);
         step();
      end
      idle();
      chk("join_tx_level8", 32'(tx_level), 32'd8);
      chk("join_tx_full", 32'(tx_full), 32'd1);
      chk("join_tx_head", tx_dout, 32'hE0);
      chk("join_rx_full", 32'(rx_full), 32'd1);
      chk("join_rx_empty", 32'(rx_empty), 32'd1);
      chk("join_rx_level", 32'(rx_level), 32'd0);
      chk("join_flags0", 32'(dbg_flags), 32'd0);
      sm_en = 1; rx_push = 1; rx_din = 32'h55;
      step();
      idle();
      chk("join_rx_stall", 32'(dbg_flags), 32'h1);
      chk("join_rx_level_still0", 32'(rx_level), 32'd0);
      join_tx = 0;
      step();
      chk("unjoin_tx_level", 32'(tx_level), 32'd0);
      chk("unjoin_tx_empty", 32'(tx_empty), 32'd1);
      chk("unjoin_tx_dout", tx_dout, 32'd0);
      step();
      chk("unjoin_tx_full", 32'(tx_full), 32'd0);
      chk("unjoin_rx_full", 32'(rx_full), 32'd0);

      // asynchronous reset mid-stream
      flush_all();
      for (int i = 0; i < 3; i++) begin
         host_wr = 1; host_wdata = 32'hF0 + 32'(i);
         step();
      end
      idle();
      host_rd = 1;
      step();
      idle();
      chk("pre_rst_level", 32'(tx_level), 32'd3);
      chk("pre_rst_flags", 32'(dbg_flags), 32'h4);
      #2 reset = 0;
      #1;
      chk("async_tx_level", 32'(tx_level), 32'd0);
      chk("async_flags", 32'(dbg_flags), 32'd0);
      chk("async_tx_empty", 32'(tx_empty), 32'd1);
      chk("async_tx_dout", tx_dout, 32'd0);
      #2 reset = 1;

      // set wins over same-cycle clear
      host_rd = 1; dbg_clr = 4'h4;
      step();
      idle();
      chk("under_set_wins", 32'(dbg_flags), 32'h4);
      dbg_clr = 4'h4;
      step();
      idle();
      chk("under_cleared", 32'(dbg_flags), 32'h0);

      // randomized traffic against the reference model
      #2 reset = 0;
      #2 reset = 1;
      join_tx = 0; join_rx = 0;
      mq_tx.delete(); mq_rx.delete();
      m_flags = 4'h0; m_cfg = 2'b00;
      for (int c = 0; c < 3000 && n_bad < 50; c++) begin
         idle();
         host_wr    = ($urandom_range(0, 1) == 1);
         host_wdata = $urandom;
         host_rd    = ($urandom_range(0, 2) == 0);
         sm_en      = ($urandom_range(0, 3) != 0);
         tx_pull    = ($urandom_range(0, 1) == 1);
         rx_push    = ($urandom_range(0, 1) == 1);
         rx_din     = $urandom;
         clear      = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 7) == 0) dbg_clr = 4'($urandom);
         if (c > 4 && $urandom_range(0, 39) == 0) {join_tx, join_rx} = 2'($urandom);
         model_edge();
         step();
         model_check();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
